// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared encodings for the pipeline hazard controller: comparator
//            forward selects, freeze FSM states and the register match helper.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Forward select encoding, shared with the ID-stage comparator operand mux
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Freeze tracking FSM
  typedef enum logic [0:0] {
    FRZ_RUN    = 1'b0,
    FRZ_FROZEN = 1'b1
  } frz_state_e;

  // A destination register matches a source only when it is not $0
  function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
    return (dest != 5'd0) && (dest == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up counter that sticks at all-ones; clear beats increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard controller for a 5-stage MIPS pipeline with branches
//            resolved in ID. Produces stall/bubble/flush/freeze sequencing,
//            ID comparator forward selects, event counters and a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_flush_req,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dest,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_dest,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             freeze,
  output logic [1:0]       forwardC,
  output logic [1:0]       forwardD,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             err_deadlock
);

  localparam int                  STREAK_W    = $clog2(MAX_STALL + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_STALL);
  localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(MAX_STALL - 1);

  // Per-stage source matches ($0 never matches)
  logic rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem, rs_hit_wb, rt_hit_wb;
  logic hit_ex, hit_mem;
  logic load_use, br_ex, br_load, stall_raw;
  logic freeze_raw, stall_g, flush_g;
  logic [1:0] fwd_c, fwd_d;

  assign rs_hit_ex  = reg_match(ex_dest,  id_rs);
  assign rt_hit_ex  = reg_match(ex_dest,  id_rt) & id_uses_rt;
  assign rs_hit_mem = reg_match(mem_dest, id_rs);
  assign rt_hit_mem = reg_match(mem_dest, id_rt) & id_uses_rt;
  assign rs_hit_wb  = reg_match(wb_dest,  id_rs);
  assign rt_hit_wb  = reg_match(wb_dest,  id_rt) & id_uses_rt;
  assign hit_ex     = rs_hit_ex  | rt_hit_ex;
  assign hit_mem    = rs_hit_mem | rt_hit_mem;

  // Stall sources: a load feeding ID, or a branch whose operand is not yet
  // available to the ID comparator (ALU result in EX, load result in MEM)
  assign load_use   = ex_mem_read & hit_ex;
  assign br_ex      = id_branch & ex_reg_write & hit_ex;
  assign br_load    = id_branch & mem_mem_read & hit_mem;
  assign stall_raw  = load_use | br_ex | br_load;

  // Priority freeze > stall > flush; a flush waits until the branch operands
  // are resolved so the branch is re-evaluated after the stall
  assign freeze_raw = ~imem_ready | ~dmem_ready;
  assign stall_g    = stall_raw & ~freeze_raw;
  assign flush_g    = id_flush_req & ~stall_g & ~freeze_raw;

  // Comparator forwarding; a load in EX/MEM has no data yet, so it is excluded
  always_comb begin
    fwd_c = FWD_RF;
    if (mem_reg_write && !mem_mem_read && rs_hit_mem) begin
      fwd_c = FWD_MEM;
    end else if (wb_reg_write && rs_hit_wb) begin
      fwd_c = FWD_WB;
    end
    fwd_d = FWD_RF;
    if (mem_reg_write && !mem_mem_read && rt_hit_mem) begin
      fwd_d = FWD_MEM;
    end else if (wb_reg_write && rt_hit_wb) begin
      fwd_d = FWD_WB;
    end
  end

  // Output drive, with the pipeline held and ID/EX bubbled during reset
  always_comb begin
    pc_write     = ~reset & ~freeze_raw & ~stall_g;
    if_id_write  = ~reset & ~freeze_raw & ~stall_g;
    if_id_flush  = ~reset & flush_g;
    id_ex_bubble = reset | stall_g;
    freeze       = ~reset & freeze_raw;
    forwardC     = reset ? FWD_RF : fwd_c;
    forwardD     = reset ? FWD_RF : fwd_d;
  end

  // Freeze tracking FSM (observability only; outputs do not depend on it)
  frz_state_e state_q;
  frz_state_e state_d;

  // Next freeze state
  always_comb begin
    state_d = state_q;
    case (state_q)
      FRZ_RUN:    if (freeze_raw)  state_d = FRZ_FROZEN;
      FRZ_FROZEN: if (!freeze_raw) state_d = FRZ_RUN;
      default:    state_d = FRZ_RUN;
    endcase
  end

  // Freeze state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FRZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // The tracked state always reflects the previous cycle's freeze
  a_frz_track: assert property (@(posedge clk) disable iff (reset)
    freeze_raw |=> (state_q == FRZ_FROZEN));

  // Watchdog: consecutive stall streak, held while frozen
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                err_q;
  logic                err_d;

  // Streak and sticky error next-state
  always_comb begin
    streak_d = streak_q;
    err_d    = err_q;
    if (cnt_clear) begin
      streak_d = '0;
      err_d    = 1'b0;
    end else if (stall_g) begin
      if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
      if (streak_q >= STREAK_LAST) begin
        err_d = 1'b1;
      end
    end else if (!freeze_raw) begin
      streak_d = '0;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  assign err_deadlock = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_g),
    .clr   (cnt_clear),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_g),
    .clr   (cnt_clear),
    .cnt   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (freeze_raw),
    .clr   (cnt_clear),
    .cnt   (freeze_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed-vector bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_dest, mem_dest, wb_dest;
  logic             id_uses_rt, id_branch, id_flush_req;
  logic             ex_reg_write, ex_mem_read;
  logic             mem_reg_write, mem_mem_read, wb_reg_write;
  logic             imem_ready, dmem_ready, cnt_clear;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze;
  logic [1:0]       forwardC, forwardD;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic             err_deadlock;

  int vec_cnt = 0;
  int err_cnt = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MAX_STALL(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_branch     (id_branch),
    .id_flush_req  (id_flush_req),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_dest       (ex_dest),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_dest      (mem_dest),
    .wb_reg_write  (wb_reg_write),
    .wb_dest       (wb_dest),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .cnt_clear     (cnt_clear),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .freeze        (freeze),
    .forwardC      (forwardC),
    .forwardD      (forwardD),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .freeze_cnt    (freeze_cnt),
    .err_deadlock  (err_deadlock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let inputs be changed away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_branch = 1'b0;
    id_flush_req = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_dest = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
    mem_dest = 5'd0; wb_reg_write = 1'b0; wb_dest = 5'd0;
    imem_ready = 1'b1; dmem_ready = 1'b1; cnt_clear = 1'b0;
  endtask

  // lw $2 in EX, add $3,$2,$4 in ID
  task automatic load_use_on();
    idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd2;
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;

    // Reset with hazards/forwards present: outputs forced
    load_use_on();
    wb_reg_write = 1'b1; wb_dest = 5'd4;
    step(); step();
    chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst_if_id_write", {31'd0, if_id_write}, 32'd0);
    chk("rst_bubble", {31'd0, id_ex_bubble}, 32'd1);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_fwdD", {30'd0, forwardD}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_err", {31'd0, err_deadlock}, 32'd0);

    // Load-use: one stall cycle
    idle(); reset = 1'b0;
    load_use_on();
    settle();
    chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
    chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
    step();
    idle();
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_dest = 5'd2;
    settle();
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    chk("lu_release_pc", {31'd0, pc_write}, 32'd1);
    chk("lu_fwdC_load_mem", {30'd0, forwardC}, 32'd0);

    // addi $5 in EX, beq $5,$6 taken in ID: one stall then forward from EX/MEM
    idle();
    ex_reg_write = 1'b1; ex_dest = 5'd5;
    id_branch = 1'b1; id_rs = 5'd5; id_rt = 5'd6; id_uses_rt = 1'b1;
    id_flush_req = 1'b1;
    settle();
    chk("brex_bubble", {31'd0, id_ex_bubble}, 32'd1);
    chk("brex_flush_blocked", {31'd0, if_id_flush}, 32'd0);
    step();
    ex_reg_write = 1'b0; ex_dest = 5'd0;
    mem_reg_write = 1'b1; mem_dest = 5'd5;
    settle();
    chk("brex_stall_cnt", stall_cnt, 32'd2);
    chk("brex_fwdC", {30'd0, forwardC}, 32'd2);
    chk("brex_fwdD", {30'd0, forwardD}, 32'd0);
    chk("brex_flush", {31'd0, if_id_flush}, 32'd1);
    chk("brex_bubble_off", {31'd0, id_ex_bubble}, 32'd0);
    step();
    chk("brex_flush_cnt", flush_cnt, 32'd1);

    // lw $7 in EX, beq $7,$0 taken: two stalls, then forward from MEM/WB
    idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd7;
    id_branch = 1'b1; id_rs = 5'd7; id_rt = 5'd0; id_uses_rt = 1'b1;
    id_flush_req = 1'b1;
    settle();
    chk("brld_stall1", {31'd0, id_ex_bubble}, 32'd1);
    step();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dest = 5'd0;
    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_dest = 5'd7;
    settle();
    chk("brld_stall2", {31'd0, id_ex_bubble}, 32'd1);
    chk("brld_flush_blocked", {31'd0, if_id_flush}, 32'd0);
    step();
    mem_mem_read = 1'b0; mem_reg_write = 1'b0; mem_dest = 5'd0;
    wb_reg_write = 1'b1; wb_dest = 5'd7;
    settle();
    chk("brld_no_stall", {31'd0, id_ex_bubble}, 32'd0);
    chk("brld_fwdC", {30'd0, forwardC}, 32'd1);
    chk("brld_flush", {31'd0, if_id_flush}, 32'd1);
    step();
    chk("brld_stall_cnt", stall_cnt, 32'd4);
    chk("brld_flush_cnt", flush_cnt, 32'd2);
    chk("brld_no_err", {31'd0, err_deadlock}, 32'd0);

    // Freeze overrides stall and flush for 3 cycles
    load_use_on();
    id_flush_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("frz_freeze", {31'd0, freeze}, 32'd1);
      chk("frz_flush", {31'd0, if_id_flush}, 32'd0);
      chk("frz_bubble", {31'd0, id_ex_bubble}, 32'd0);
      chk("frz_pc_write", {31'd0, pc_write}, 32'd0);
      step();
    end
    idle();
    settle();
    chk("frz_cnt", freeze_cnt, 32'd3);
    chk("frz_released", {31'd0, freeze}, 32'd0);
    chk("frz_stall_cnt", stall_cnt, 32'd4);
    step();

    // Deadlock watchdog: 4 consecutive stalls
    load_use_on();
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("wd_err", {31'd0, err_deadlock}, (i == 4) ? 32'd1 : 32'd0);
    end
    idle();
    step();
    chk("wd_sticky", {31'd0, err_deadlock}, 32'd1);
    chk("wd_stall_cnt", stall_cnt, 32'd8);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_err", {31'd0, err_deadlock}, 32'd0);
    chk("clr_stall_cnt", stall_cnt, 32'd0);
    chk("clr_flush_cnt", flush_cnt, 32'd0);
    chk("clr_freeze_cnt", freeze_cnt, 32'd0);

    // Streak holds across a frozen cycle: 2 stalls + freeze + 2 stalls
    load_use_on();
    step(); step();
    dmem_ready = 1'b0;
    step();
    dmem_ready = 1'b1;
    step();
    chk("wdh_err_pre", {31'd0, err_deadlock}, 32'd0);
    step();
    chk("wdh_err", {31'd0, err_deadlock}, 32'd1);
    idle();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;

    // $0 never hazards or forwards; rt ignored when not used
    idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd0;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    id_uses_rt = 1'b1;
    settle();
    chk("r0_bubble", {31'd0, id_ex_bubble}, 32'd0);
    chk("r0_fwdC", {30'd0, forwardC}, 32'd0);
    chk("r0_fwdD", {30'd0, forwardD}, 32'd0);
    chk("r0_pc_write", {31'd0, pc_write}, 32'd1);
    idle();
    ex_mem_read = 1'b1; ex_dest = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b0;
    wb_reg_write = 1'b1; wb_dest = 5'd3;
    settle();
    chk("nort_bubble", {31'd0, id_ex_bubble}, 32'd0);
    chk("nort_fwdD", {30'd0, forwardD}, 32'd0);
    id_uses_rt = 1'b1;
    ex_mem_read = 1'b0;
    mem_reg_write = 1'b1; mem_dest = 5'd3;
    settle();
    chk("rt_fwdD_mem_prio", {30'd0, forwardD}, 32'd2);
    step();

    // Reset mid-stall discards counters and streak
    load_use_on();
    step();
    chk("rms_stall_cnt", stall_cnt, 32'd1);
    reset = 1'b1;
    settle();
    chk("rms_pc_write", {31'd0, pc_write}, 32'd0);
    chk("rms_bubble", {31'd0, id_ex_bubble}, 32'd1);
    step();
    reset = 1'b0;
    settle();
    chk("rms_stall_cnt_clr", stall_cnt, 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("rms_streak_discard", {31'd0, err_deadlock}, 32'd0);
    chk("rms_stall_cnt3", stall_cnt, 32'd3);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
